// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types/constants for the MEM stage     | rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] REG_ZERO_DATA = 32'h0000_0000;

    // funct3[1:0] carries the access size; funct3[2] only selects zero-extension
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : data-bus req/gnt/rvalid handshake bundle      | rev 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// ============================================================================
// mem_stage_lsu_align : byte-lane steering, load extension, misalign detect | rev 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = load_data[7:0];
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            default: byte_sel = load_data[31:24];
        endcase
        half_sel = offset[1] ? load_data[31:16] : load_data[15:0];
    end

    always_comb begin
        wdata    = store_data;
        wstrb    = 4'b1111;
        load_ext = load_data;
        misalign = is_misaligned(funct3, offset);
        case (funct3[1:0])
            2'b00: begin
                wdata    = {4{store_data[7:0]}};
                wstrb    = 4'b0001 << offset;
                load_ext = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                wdata    = {2{store_data[15:0]}};
                wstrb    = offset[1] ? 4'b1100 : 4'b0011;
                load_ext = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                wdata    = store_data;
                wstrb    = 4'b1111;
                load_ext = load_data;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : RV32I MEM stage - data-bus FSM, timeout, MEM/WB register | rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    input  logic        flush,
    mem_stage_if.master dbus,
    output logic        stall,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misalign,
    output logic        bus_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        kill_q;
    logic        hit_q;
    logic [31:0] rdata_q;

    logic        is_mem;
    logic        live;
    logic        launch;
    logic        bad_align;
    logic        resp_valid;
    logic        done;
    logic        timeout;
    logic [1:0]  al_off;
    logic [2:0]  al_f3;
    logic [31:0] resp_data;
    logic [31:0] al_wdata;
    logic [31:0] al_ext;
    logic [3:0]  al_wstrb;
    logic        al_mis;

    // Aligner sees the live instruction in IDLE and the latched access otherwise
    always_comb begin
        is_mem     = mem_read | mem_write;
        live       = valid & ~flush & (state == ST_IDLE);
        al_off     = (state == ST_IDLE) ? alu_result[1:0] : off_q;
        al_f3      = (state == ST_IDLE) ? funct3 : f3_q;
        resp_valid = hit_q | dbus.rvalid;
        resp_data  = hit_q ? rdata_q : dbus.rdata;
    end

    mem_stage_lsu_align u_align (
        .offset     (al_off),
        .funct3     (al_f3),
        .store_data (store_data),
        .load_data  (resp_data),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_ext   (al_ext),
        .misalign   (al_mis)
    );

    // A same-cycle gnt+rvalid in REQ is captured and retired from RESP next cycle
    always_comb begin
        launch    = live & is_mem & ~al_mis;
        bad_align = live & is_mem & al_mis;
        done      = (state == ST_RESP) & resp_valid;
        timeout   = (cnt == CNT_LAST) &
                    (((state == ST_REQ) & ~(dbus.gnt & dbus.rvalid)) |
                     ((state == ST_RESP) & ~resp_valid));
        stall     = launch | (state == ST_REQ) | ((state == ST_RESP) & ~resp_valid);
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_REQ;
            ST_REQ: begin
                if (timeout)       state_nxt = ST_IDLE;
                else if (dbus.gnt) state_nxt = ST_RESP;
            end
            ST_RESP: if (done | timeout) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= ((state == ST_IDLE) || (state_nxt == ST_IDLE)) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.addr  <= REG_ZERO_DATA;
            dbus.wdata <= REG_ZERO_DATA;
            dbus.wstrb <= 4'b0000;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            rd_q       <= 5'd0;
            rw_q       <= 1'b0;
            kill_q     <= 1'b0;
            hit_q      <= 1'b0;
            rdata_q    <= REG_ZERO_DATA;
        end else begin
            if (launch) begin
                dbus.req   <= 1'b1;
                dbus.we    <= mem_write;
                dbus.addr  <= {alu_result[31:2], 2'b00};
                dbus.wdata <= al_wdata;
                dbus.wstrb <= al_wstrb;
                off_q      <= alu_result[1:0];
                f3_q       <= funct3;
                rd_q       <= rd_addr;
                rw_q       <= reg_write & mem_read;
                kill_q     <= 1'b0;
                hit_q      <= 1'b0;
            end else if (state == ST_REQ) begin
                if (dbus.gnt | timeout) dbus.req <= 1'b0;
                if (dbus.gnt & dbus.rvalid) begin
                    hit_q   <= 1'b1;
                    rdata_q <= dbus.rdata;
                end
            end
            if ((state != ST_IDLE) && flush) kill_q <= 1'b1;
        end
    end

    // MEM/WB: a bubble unless a non-memory op passes or an un-killed load retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data      <= REG_ZERO_DATA;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_data      <= REG_ZERO_DATA;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            if (live & ~is_mem) begin
                wb_data      <= alu_result;
                wb_rd        <= rd_addr;
                wb_reg_write <= reg_write;
            end else if (done & ~dbus.we & ~kill_q & ~flush) begin
                wb_data      <= al_ext;
                wb_rd        <= rd_q;
                wb_reg_write <= rw_q;
            end
            misalign <= bad_align;
            bus_err  <= timeout;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed + randomized checks of mem_stage against a bench model | rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int TMO = 8;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        flush;
    logic        stall;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    mem_stage_if dbus ();

    mem_stage #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid        (valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .flush        (flush),
        .dbus         (dbus),
        .stall        (stall),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misalign     (misalign),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pick the addressed byte/half arithmetically, then extend
    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] r;
        sh = d >> (8 * off);
        case (f3)
            3'b000:  begin r = sh & 32'hFF;   if (r[7])  r = r | 32'hFFFF_FF00; end
            3'b100:  r = sh & 32'hFF;
            3'b001:  begin r = sh & 32'hFFFF; if (r[15]) r = r | 32'hFFFF_0000; end
            3'b101:  r = sh & 32'hFFFF;
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0;
    endtask

    task automatic do_alu(input logic [31:0] val, input logic [4:0] rd, input logic rw);
        valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0; alu_result = val;
        rd_addr = rd; reg_write = rw; flush = 1'b0; funct3 = 3'($urandom);
        #1 chk("alu_stall", stall, 0);
        @(posedge clk); #1;
        chk("alu_wb_data", wb_data, val);
        chk("alu_wb_rd", wb_rd, rd);
        chk("alu_wb_we", wb_reg_write, rw);
        idle_inputs();
    endtask

    // One ld/st: gdly cycles before gnt, rvalid rdly cycles after gnt (-1 = never)
    task automatic do_mem(input logic rd_op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                          input int gdly, input int rdly, input logic [31:0] rdat, input int fl_cyc);
        logic [1:0]  off;
        logic        mis;
        logic        killed;
        logic        tmo;
        logic [31:0] ew;
        logic [3:0]  es;
        int          compl;
        int          last;
        off = addr[1:0];
        mis = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        valid = 1'b1; mem_read = rd_op; mem_write = !rd_op; alu_result = addr;
        store_data = sdata; funct3 = f3; rd_addr = rd; reg_write = rw; flush = 1'b0;
        #1;
        if (mis) begin
            chk("mis_stall", stall, 0);
            @(posedge clk); #1;
            chk("mis_pulse", misalign, 1);
            chk("mis_wb_we", wb_reg_write, 0);
            chk("mis_req", dbus.req, 0);
            idle_inputs();
            @(posedge clk); #1;
            chk("mis_pulse_end", misalign, 0);
            chk("mis_req_after", dbus.req, 0);
            return;
        end
        chk("launch_stall", stall, 1);
        @(posedge clk); #1;
        chk("bus_we", dbus.we, !rd_op);
        chk("bus_addr", dbus.addr, addr & 32'hFFFF_FFFC);
        if (!rd_op) begin
            case (f3[1:0])
                2'b00:   begin ew = (sdata & 32'hFF) * 32'h0101_0101;   es = 4'(1 << off); end
                2'b01:   begin ew = (sdata & 32'hFFFF) * 32'h0001_0001; es = (off >= 2) ? 4'hC : 4'h3; end
                default: begin ew = sdata; es = 4'hF; end
            endcase
            chk("bus_wdata", dbus.wdata, ew);
            chk("bus_wstrb", {28'h0, dbus.wstrb}, {28'h0, es});
        end
        if (rdly < 0)       compl = 1000;
        else if (rdly == 0) compl = gdly + 1;
        else                compl = gdly + rdly;
        tmo    = (compl > TMO - 1);
        last   = tmo ? TMO - 1 : compl;
        killed = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            chk("req_level", dbus.req, (c <= gdly));
            chk("inflight_wb_we", wb_reg_write, 0);
            dbus.gnt    = (c == gdly);
            dbus.rvalid = (rdly >= 0) && (c == gdly + rdly);
            dbus.rdata  = dbus.rvalid ? rdat : $urandom;
            flush       = (c == fl_cyc);
            if (flush) killed = 1'b1;
            #1 chk("inflight_stall", stall, (c < last) || tmo);
        end
        @(posedge clk); #1;
        idle_inputs();
        chk("bus_err", bus_err, tmo);
        chk("req_done", dbus.req, 0);
        if (!tmo && rd_op && !killed) begin
            chk("ld_wb_data", wb_data, ext_model(f3, off, rdat));
            chk("ld_wb_rd", wb_rd, rd);
            chk("ld_wb_we", wb_reg_write, rw);
        end else begin
            chk("bubble_wb_we", wb_reg_write, 0);
        end
        #1 chk("post_stall", stall, 0);
        @(posedge clk); #1;
        chk("bus_err_end", bus_err, 0);
    endtask

    initial begin
        static logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] a;
        logic [2:0]  f;
        int          kind;
        int          g;
        int          r;
        int          fl;

        rst_n = 1'b0; alu_result = '0; store_data = '0; funct3 = '0; rd_addr = '0;
        reg_write = 1'b0; dbus.rdata = '0;
        idle_inputs();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dbus.req, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_we", wb_reg_write, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_bus_err", bus_err, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_alu(32'h0000_1234, 5'd5, 1'b1);
        do_mem(1'b1, 32'h0000_0103, 32'h0, 3'b000, 5'd9, 1'b1, 0, 0, 32'h80FF_FFFF, -1);
        do_mem(1'b0, 32'h0000_0102, 32'hABCD_1234, 3'b001, 5'd3, 1'b1, 1, 1, 32'h0, -1);
        do_mem(1'b1, 32'h0000_0101, 32'h0, 3'b010, 5'd4, 1'b1, 0, 0, 32'h0, -1);
        do_mem(1'b1, 32'h0000_0202, 32'h0, 3'b101, 5'd6, 1'b1, 3, 2, 32'hF00D_8765, -1);

        // flush while idle: dropped without touching the bus
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; alu_result = 32'h300;
        funct3 = 3'b010; rd_addr = 5'd8; reg_write = 1'b1; flush = 1'b1;
        #1 chk("flush_idle_stall", stall, 0);
        @(posedge clk); #1;
        chk("flush_idle_req", dbus.req, 0);
        chk("flush_idle_wb_we", wb_reg_write, 0);
        idle_inputs();

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a    = $urandom;
            g    = $urandom_range(0, 4);
            r    = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, g + r + 1) : -1;
            if (kind == 0) begin
                do_alu(a, 5'($urandom), 1'($urandom));
            end else if (kind == 1) begin
                f = ld_f3[$urandom_range(0, 4)];
                do_mem(1'b1, a, $urandom, f, 5'($urandom), 1'($urandom), g, r, $urandom, fl);
            end else begin
                f = 3'($urandom_range(0, 2));
                do_mem(1'b0, a, $urandom, f, 5'($urandom), 1'b0, g, r, 32'h0, fl);
            end
        end

        do_mem(1'b1, 32'h0000_0400, 32'h0, 3'b010, 5'd7, 1'b1, 0, -1, 32'h0, -1);
        do_mem(1'b1, 32'h0000_0404, 32'h0, 3'b010, 5'd7, 1'b1, 0, 3, 32'h1234_5678, 2);
        do_mem(1'b1, 32'h0000_0408, 32'h0, 3'b010, 5'd7, 1'b1, 2, -1, 32'h0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
